// File: rtl/main_memory_model.sv
// Line-granular main-memory back end: models access latency plus a word-serial line transfer.
// Writes are posted; reads finish with a one-cycle ready_mem pulse and the line held on rd_line.
module main_memory_model #(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int MEM_LINES  = 1024,
    parameter int ADDR_W     = 32,
    parameter int LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_en_mem,
    input  logic                         write_en_mem,
    input  logic [ADDR_W-1:0]            line_addr,
    input  logic [WORD_W*LINE_WORDS-1:0] wr_line,
    output logic [WORD_W*LINE_WORDS-1:0] rd_line,
    output logic                         ready_mem,
    output logic                         busy,
    output logic                         protocol_err
);
    localparam int LINE_W = WORD_W * LINE_WORDS;
    localparam int IDX_W  = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int WC_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LC_W   = $clog2(LATENCY + 1);
    localparam int MA_W   = (MEM_LINES * LINE_WORDS > 1) ? $clog2(MEM_LINES * LINE_WORDS) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, W_LAT, W_XFER, R_LAT, R_XFER, R_DONE} state_t;

    state_t            state_q, state_d;
    logic [LC_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wbuf_q, wbuf_d;
    logic [LINE_W-1:0] rd_line_q, rd_line_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              perr_q, perr_d;
    logic              wr_en_q;
    logic              wr_edge;

    logic [WORD_W-1:0] mem_q [MEM_LINES*LINE_WORDS];
    logic [MA_W-1:0]   mem_addr;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;

    if (ADDR_W > IDX_W) begin : g_addr_hi
        logic addr_hi_unused;
        assign addr_hi_unused = ^line_addr[ADDR_W-1:IDX_W];
    end

    assign wr_edge   = write_en_mem & ~wr_en_q;
    assign mem_addr  = MA_W'(int'(idx_q) * LINE_WORDS + int'(word_cnt_q));
    assign mem_rdata = mem_q[mem_addr];

    always_comb begin
        mem_wdata = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (word_cnt_q == WC_W'(i)) mem_wdata = wbuf_q[i*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        word_cnt_d = word_cnt_q;
        idx_d      = idx_q;
        wbuf_d     = wbuf_q;
        rd_line_d  = rd_line_q;
        ready_d    = 1'b0;
        mem_we     = 1'b0;
        // any write edge outside IDLE is dropped and flagged
        perr_d     = perr_q | (wr_edge & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (wr_edge) begin
                    idx_d      = line_addr[IDX_W-1:0];
                    wbuf_d     = wr_line;
                    lat_cnt_d  = LC_W'(LATENCY);
                    word_cnt_d = '0;
                    state_d    = W_LAT;
                end else if (read_en_mem) begin
                    idx_d      = line_addr[IDX_W-1:0];
                    lat_cnt_d  = LC_W'(LATENCY);
                    word_cnt_d = '0;
                    state_d    = R_LAT;
                end
            end
            W_LAT, R_LAT: begin
                if (lat_cnt_q <= LC_W'(1)) state_d = (state_q == W_LAT) ? W_XFER : R_XFER;
                else lat_cnt_d = lat_cnt_q - 1'b1;
            end
            W_XFER: begin
                mem_we = ~rst;
                if (word_cnt_q == WC_LAST) state_d = IDLE;
                else word_cnt_d = word_cnt_q + 1'b1;
            end
            R_XFER: begin
                for (int i = 0; i < LINE_WORDS; i++) begin
                    if (word_cnt_q == WC_W'(i)) rd_line_d[i*WORD_W +: WORD_W] = mem_rdata;
                end
                if (word_cnt_q == WC_LAST) begin
                    state_d = R_DONE;
                    ready_d = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            R_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            word_cnt_q <= '0;
            idx_q      <= '0;
            wbuf_q     <= '0;
            rd_line_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            word_cnt_q <= word_cnt_d;
            idx_q      <= idx_d;
            wbuf_q     <= wbuf_d;
            rd_line_q  <= rd_line_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            perr_q     <= perr_d;
            wr_en_q    <= write_en_mem;
        end
    end

    assign rd_line      = rd_line_q;
    assign ready_mem    = ready_q;
    assign busy         = busy_q;
    assign protocol_err = perr_q;
endmodule

// File: tb/tb_main_memory_model.sv
// Randomized self-checking bench for main_memory_model: a line-array model plus
// latency arithmetic (LATENCY + LINE_WORDS + 1) predict data and ready/busy timing.
module tb_main_memory_model;
    localparam int LAT     = 4;
    localparam int LW      = 4;
    localparam int RD_CYC  = LAT + LW + 1;
    localparam int WR_IDLE = LAT + LW + 1;
    localparam int RD_CYC2 = 1 + 1 + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en, wr_en;
    logic [31:0]  addr;
    logic [127:0] wr_line, rd_line;
    logic         ready, busy, perr;
    logic         rd_en2, wr_en2;
    logic [31:0]  addr2, wr_line2, rd_line2;
    logic         ready2, busy2, perr2;

    int total = 0;
    int bad   = 0;
    logic [127:0] model [int];

    always #5 clk = ~clk;

    main_memory_model u_dut (
        .clk(clk), .rst(rst), .read_en_mem(rd_en), .write_en_mem(wr_en),
        .line_addr(addr), .wr_line(wr_line), .rd_line(rd_line),
        .ready_mem(ready), .busy(busy), .protocol_err(perr)
    );

    main_memory_model #(.LINE_WORDS(1), .LATENCY(1)) u_dut2 (
        .clk(clk), .rst(rst), .read_en_mem(rd_en2), .write_en_mem(wr_en2),
        .line_addr(addr2), .wr_line(wr_line2), .rd_line(rd_line2),
        .ready_mem(ready2), .busy(busy2), .protocol_err(perr2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Posted write; wr_en held two cycles, inputs scrambled after acceptance.
    task automatic do_write(input logic [31:0] a, input logic [127:0] d,
                            output int idle_at, output int readies);
        wr_en = 1'b1; addr = a; wr_line = d;
        idle_at = -1; readies = 0;
        for (int n = 1; n <= WR_IDLE + 2; n++) begin
            cyc();
            if (n == 1) begin addr = $urandom; wr_line = rand_line(); end
            if (n == 2) wr_en = 1'b0;
            if (ready) readies++;
            if (!busy && idle_at < 0) idle_at = n;
        end
        model[int'(a[9:0])] = d;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [127:0] got, output int lat);
        rd_en = 1'b1; addr = a; lat = -1; got = '0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (n == 1) addr = $urandom;
            if (ready) begin
                lat = n; got = rd_line; rd_en = 1'b0;
                break;
            end
        end
        rd_en = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 0; wr_en = 0; addr = 0; wr_line = 0;
        rd_en2 = 0; wr_en2 = 0; addr2 = 0; wr_line2 = 0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        cyc();
        total++;
        if ({ready, busy, perr} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {ready, busy, perr});
        end
        total++;
        if (rd_line !== 128'h0) begin
            bad++; $display("FAIL reset_rd_line got=%h exp=0", rd_line);
        end
    endtask

    task automatic test_read_basic();
        logic [127:0] d;
        int idle_at, readies, ready_n;
        d = rand_line();
        do_write(32'd5, d, idle_at, readies);
        rd_en = 1'b1; addr = 32'd5; ready_n = -1;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (n == 1) addr = $urandom;
            total++;
            if (ready !== (n == RD_CYC) || busy !== (n <= RD_CYC)) begin
                bad++; $display("FAIL read1_timing cyc=%0d got ready=%b busy=%b exp ready=%b busy=%b",
                                n, ready, busy, n == RD_CYC, n <= RD_CYC);
            end
            if (ready) begin ready_n = n; rd_en = 1'b0; end
        end
        rd_en = 1'b0;
        total++;
        if (rd_line !== model[5]) begin
            bad++; $display("FAIL read1_data got=%h exp=%h", rd_line, model[5]);
        end
    endtask

    task automatic test_write();
        logic [127:0] got;
        int idle_at, readies, lat;
        do_write(32'd7, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, idle_at, readies);
        total++;
        if (idle_at !== WR_IDLE) begin
            bad++; $display("FAIL write_idle got=%0d exp=%0d", idle_at, WR_IDLE);
        end
        total++;
        if (readies !== 0 || perr !== 1'b0) begin
            bad++; $display("FAIL write_side got readies=%0d perr=%b exp 0/0", readies, perr);
        end
        do_read(32'd7, got, lat);
        total++;
        if (lat !== RD_CYC || got !== 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD) begin
            bad++; $display("FAIL write_readback got lat=%0d data=%h exp lat=%0d data=%h",
                            lat, got, RD_CYC, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        end
    endtask

    task automatic test_same_cycle();
        logic [127:0] nd, got;
        int idle_at, readies, ready_n, cnt;
        logic busy_at_idle;
        do_write(32'd3, rand_line(), idle_at, readies);
        nd = rand_line();
        wr_en = 1'b1; rd_en = 1'b1; addr = 32'd3; wr_line = nd;
        ready_n = -1; cnt = 0; got = '0; busy_at_idle = 1'bx;
        for (int n = 1; n <= 25; n++) begin
            cyc();
            if (n == 2) wr_en = 1'b0;
            if (n == WR_IDLE) busy_at_idle = busy;
            if (ready) begin
                cnt++;
                if (ready_n < 0) begin ready_n = n; got = rd_line; end
                rd_en = 1'b0;
            end
        end
        rd_en = 1'b0;
        model[3] = nd;
        total++;
        if (busy_at_idle !== 1'b0) begin
            bad++; $display("FAIL same_write_idle got busy=%b exp=0 at cyc %0d", busy_at_idle, WR_IDLE);
        end
        total++;
        if (ready_n !== WR_IDLE + RD_CYC || cnt !== 1) begin
            bad++; $display("FAIL same_read_time got=%0d pulses=%0d exp=%0d pulses=1",
                            ready_n, cnt, WR_IDLE + RD_CYC);
        end
        total++;
        if (got !== nd) begin
            bad++; $display("FAIL same_read_data got=%h exp=%h", got, nd);
        end
    endtask

    task automatic test_write_while_busy();
        logic [127:0] old, got;
        int idle_at, readies, ready_n, lat;
        old = rand_line();
        do_write(32'd9, old, idle_at, readies);
        total++;
        if (perr !== 1'b0) begin
            bad++; $display("FAIL busy_perr_pre got=%b exp=0", perr);
        end
        rd_en = 1'b1; addr = 32'd9; ready_n = -1; got = '0;
        for (int n = 1; n <= 15; n++) begin
            cyc();
            if (n == 2) begin wr_en = 1'b1; wr_line = rand_line(); end
            if (n == 6) wr_en = 1'b0;
            if (ready && ready_n < 0) begin ready_n = n; got = rd_line; rd_en = 1'b0; end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        total++;
        if (ready_n !== RD_CYC || got !== old) begin
            bad++; $display("FAIL busy_read got lat=%0d data=%h exp lat=%0d data=%h", ready_n, got, RD_CYC, old);
        end
        total++;
        if (perr !== 1'b1) begin
            bad++; $display("FAIL busy_perr_set got=%b exp=1", perr);
        end
        do_read(32'd9, got, lat);
        total++;
        if (got !== model[9] || perr !== 1'b1) begin
            bad++; $display("FAIL busy_dropped got data=%h perr=%b exp data=%h perr=1", got, perr, model[9]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int lat;
        rd_en = 1'b1; addr = 32'd5;
        for (int n = 1; n <= 6; n++) cyc();
        rst = 1'b1; rd_en = 1'b0;
        cyc();
        total++;
        if ({ready, busy, perr} !== 3'b000 || rd_line !== 128'h0) begin
            bad++; $display("FAIL midrst_state got flags=%b rd_line=%h exp 000 / 0", {ready, busy, perr}, rd_line);
        end
        rst = 1'b0;
        cyc();
        do_read(32'd5, got, lat);
        total++;
        if (lat !== RD_CYC || got !== model[5]) begin
            bad++; $display("FAIL midrst_read got lat=%0d data=%h exp lat=%0d data=%h", lat, got, RD_CYC, model[5]);
        end
    endtask

    task automatic test_random();
        logic [127:0] got, d;
        logic [31:0] a;
        int idx, idle_at, readies, lat;
        for (int it = 0; it < 24; it++) begin
            idx = int'($urandom_range(0, 15));
            a = ($urandom & 32'hFFFF_FC00) | 32'(idx);
            if (!model.exists(idx) || $urandom_range(0, 1) == 0) begin
                d = rand_line();
                do_write(a, d, idle_at, readies);
                total++;
                if (idle_at !== WR_IDLE || readies !== 0) begin
                    bad++; $display("FAIL rand_write it=%0d got idle=%0d readies=%0d exp idle=%0d readies=0",
                                    it, idle_at, readies, WR_IDLE);
                end
            end else begin
                do_read(a, got, lat);
                total++;
                if (lat !== RD_CYC || got !== model[idx]) begin
                    bad++; $display("FAIL rand_read it=%0d idx=%0d got lat=%0d data=%h exp lat=%0d data=%h",
                                    it, idx, lat, got, RD_CYC, model[idx]);
                end
            end
        end
    endtask

    task automatic test_small();
        logic [31:0] d, got;
        int idle_at, ready_n;
        d = $urandom;
        wr_en2 = 1'b1; addr2 = 32'd5; wr_line2 = d; idle_at = -1;
        for (int n = 1; n <= 5; n++) begin
            cyc();
            if (n == 2) wr_en2 = 1'b0;
            if (!busy2 && idle_at < 0) idle_at = n;
        end
        total++;
        if (idle_at !== RD_CYC2) begin
            bad++; $display("FAIL small_write_idle got=%0d exp=%0d", idle_at, RD_CYC2);
        end
        rd_en2 = 1'b1; addr2 = 32'hFFFF_FC05; ready_n = -1; got = '0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (ready2 && ready_n < 0) begin ready_n = n; got = rd_line2; rd_en2 = 1'b0; end
        end
        rd_en2 = 1'b0;
        total++;
        if (ready_n !== RD_CYC2 || got !== d) begin
            bad++; $display("FAIL small_read got lat=%0d data=%h exp lat=%0d data=%h", ready_n, got, RD_CYC2, d);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write();
        test_same_cycle();
        test_write_while_busy();
        test_reset_mid();
        test_random();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
